vga_frame_grabber: RTL and testbench



---
 rtl/vga_frame_grabber.sv | 194 +++++++++++++++++++
 tb/tb_vga_frame_grabber.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_grabber.sv
// vga_frame_grabber: Avalon-MM slave that arms on a CTRL start, aligns to the
// next VSYNC fall, and buffers active-video pixels, optionally decimated per
// line, into a FIFO. The host drains the FIFO through the DATA register.
module vga_frame_grabber #(
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned CNT_W      = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               read,
    input  logic               write,
    input  logic [1:0]         address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [COLOR_W-1:0] VGA_R,
    input  logic [COLOR_W-1:0] VGA_G,
    input  logic [COLOR_W-1:0] VGA_B,
    input  logic               VGA_BLANK_n,
    input  logic               HSYNC,
    input  logic               VSYNC,
    output logic               irq
);
    localparam int unsigned PIX_W = 3 * COLOR_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

    state_t           state_q, state_d;
    logic             hsync_q, vsync_q;
    logic             cont_q, cont_d;
    logic [3:0]       decim_q, decim_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] pixcount_q, pixcount_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             done_q, done_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [PIX_W-1:0] mem_q [FIFO_DEPTH];

    logic             vs_fall, hs_fall;
    logic             ctrl_wr, clr_wr, start, abort;
    logic             pop_req, push_req, do_pop, do_push;
    logic             fifo_empty, fifo_full;
    logic             frame_start, frame_end;
    logic [3:0]       decim_n;
    logic [PIX_W-1:0] pixel;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:4];
    assign readdata     = readdata_q;
    assign irq          = done_q;

    // Next-state logic: capture sequencing, FIFO bookkeeping, flags and register file
    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        decim_d     = decim_q;
        dcnt_d      = dcnt_q;
        pixcount_d  = pixcount_q;
        readdata_d  = readdata_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        push_req    = 1'b0;

        vs_fall    = vsync_q & ~VSYNC;
        hs_fall    = hsync_q & ~HSYNC;
        ctrl_wr    = chipselect & write & (address == 2'd0);
        clr_wr     = chipselect & write & (address == 2'd2);
        start      = ctrl_wr & writedata[0];
        abort      = ctrl_wr & writedata[1];
        pop_req    = chipselect & read & (address == 2'd1);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        decim_n    = (decim_q == 4'd0) ? 4'd1 : decim_q;
        pixel      = {VGA_R, VGA_G, VGA_B};

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (vs_fall) begin
                    state_d     = S_CAPTURE;
                    frame_start = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (vs_fall) begin
                    frame_end = 1'b1;
                    if (cont_q) frame_start = 1'b1;
                    else        state_d     = S_IDLE;
                end else begin
                    push_req = VGA_BLANK_n & (dcnt_q == 4'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decimation phase: restarts on each line and frame; >= guards a DECIM change mid-line
        if (frame_start || (state_q == S_CAPTURE && hs_fall)) begin
            dcnt_d = '0;
        end else if (state_q == S_CAPTURE && VGA_BLANK_n) begin
            dcnt_d = (dcnt_q >= decim_n - 4'd1) ? '0 : dcnt_q + 4'd1;
        end

        do_pop   = pop_req & ~fifo_empty;
        do_push  = push_req & (~fifo_full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);

        if (frame_start) begin
            pixcount_d = '0;
        end else if (do_push && pixcount_q != '1) begin
            pixcount_d = pixcount_q + CNT_W'(1);
        end

        // Set events override a coincident W1C
        ovf_d  = (ovf_q  & ~(clr_wr & writedata[1])) | (push_req & fifo_full & ~do_pop);
        udf_d  = (udf_q  & ~(clr_wr & writedata[3])) | (pop_req & fifo_empty);
        done_d = (done_q & ~(clr_wr & writedata[2])) | frame_end;

        if (ctrl_wr) cont_d = writedata[2];
        if (chipselect && write && address == 2'd3) decim_d = writedata[3:0];

        if (abort) begin
            state_d    = S_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            pixcount_d = '0;
        end

        if (chipselect && read) begin
            readdata_d = '0;
            case (address)
                2'd0: begin
                    readdata_d[16 +: LVL_W] = level_q;
                    readdata_d[3:0] = {udf_q, done_q, ovf_q, (state_q != S_IDLE)};
                end
                2'd1:    if (!fifo_empty) readdata_d[31 -: PIX_W] = mem_q[rd_ptr_q];
                2'd2:    readdata_d[CNT_W-1:0] = pixcount_q;
                default: readdata_d[3:0] = decim_q;
            endcase
        end
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            cont_q     <= 1'b0;
            decim_q    <= 4'd1;
            dcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pixcount_q <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            hsync_q    <= HSYNC;
            vsync_q    <= VSYNC;
            cont_q     <= cont_d;
            decim_q    <= decim_d;
            dcnt_q     <= dcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pixcount_q <= pixcount_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
        end
    end

    // Pixel storage
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= pixel;
    end

endmodule

// File: tb/tb_vga_frame_grabber.sv
// Bench for vga_frame_grabber: a queue-based reference model tracks every
// clock; irq and each read response are compared against it, and literal
// register values pin the model at the scenario boundaries.
module tb_vga_frame_grabber;
    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, read, write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_BLANK_n, HSYNC, VSYNC;
    logic        irq;

    always #5 clk = ~clk;

    vga_frame_grabber #(.COLOR_W(8), .FIFO_DEPTH(DEPTH), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_BLANK_n(VGA_BLANK_n),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .irq(irq)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int          m_mode;        // 0 idle, 1 waiting for frame, 2 capturing
    int unsigned m_col, m_pixcount, m_decim;
    bit          m_cont, m_ovf, m_udf, m_done, m_hs, m_vs, m_rdv;
    logic [31:0] m_rd;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_col = 0; m_pixcount = 0; m_decim = 1;
        m_cont = 0; m_ovf = 0; m_udf = 0; m_done = 0;
        m_hs = 1; m_vs = 1; m_rdv = 0; m_rd = '0;
    endtask

    task automatic model_step();
        bit          vs_fall = m_vs && !VSYNC;
        bit          hs_fall = m_hs && !HSYNC;
        bit          wr_ctrl = chipselect && write && address == 2'd0;
        bit          start   = wr_ctrl && writedata[0];
        bit          abort   = wr_ctrl && writedata[1];
        bit          pop_req = chipselect && read && address == 2'd1;
        int          n       = mq.size();
        int unsigned dn      = (m_decim == 0) ? 1 : m_decim;
        bit          want    = (m_mode == 2) && !vs_fall && VGA_BLANK_n && (m_col % dn == 0);
        bit          do_pop  = pop_req && n > 0;
        bit          do_push = want && (n < DEPTH || do_pop);
        bit          fstart  = 0;

        m_rdv = chipselect && read;
        if (chipselect && read) begin
            case (address)
                2'd0:    m_rd = {16'(n), 12'd0, m_udf, m_done, m_ovf, 1'(m_mode != 0)};
                2'd1:    m_rd = (n > 0) ? mq[0] : 32'd0;
                2'd2:    m_rd = 32'(m_pixcount);
                default: m_rd = 32'(m_decim);
            endcase
        end
        if (chipselect && write && address == 2'd2) begin
            if (writedata[1]) m_ovf  = 0;
            if (writedata[2]) m_done = 0;
            if (writedata[3]) m_udf  = 0;
        end
        if (want && n == DEPTH && !do_pop) m_ovf = 1;
        if (pop_req && n == 0) m_udf = 1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back({VGA_R, VGA_G, VGA_B, 8'h00});
            if (m_pixcount < (1 << 20) - 1) m_pixcount++;
        end
        if (hs_fall) m_col = 0;
        else if (m_mode == 2 && VGA_BLANK_n) m_col++;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: if (vs_fall) begin m_mode = 2; fstart = 1; end
            default: if (vs_fall) begin
                m_done = 1;
                if (m_cont) fstart = 1; else m_mode = 0;
            end
        endcase
        if (fstart) begin m_col = 0; m_pixcount = 0; end
        if (wr_ctrl) m_cont = writedata[2];
        if (abort) begin m_mode = 0; mq.delete(); m_pixcount = 0; end
        if (chipselect && write && address == 2'd3) m_decim = 32'(writedata[3:0]);
        m_hs = HSYNC;
        m_vs = VSYNC;
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- compare process ----------------
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("irq", {31'd0, irq}, {31'd0, m_done});
            if (m_rdv) chk("readdata", readdata, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic vid(input bit h, input bit v, input bit b,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] bb,
                       input bit pop);
        @(negedge clk);
        HSYNC = h; VSYNC = v; VGA_BLANK_n = b;
        VGA_R = r; VGA_G = g; VGA_B = bb;
        chipselect = pop; read = pop; write = 1'b0;
        address = pop ? 2'd1 : 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) vid(1, 1, 0, 8'd0, 8'd0, 8'd0, 0);
    endtask

    task automatic vs_pulse();
        repeat (2) vid(1, 1, 0, 8'd0, 8'd0, 8'd0, 0);
        repeat (2) vid(1, 0, 0, 8'd0, 8'd0, 8'd0, 0);
        repeat (2) vid(1, 1, 0, 8'd0, 8'd0, 8'd0, 0);
    endtask

    // Lines of w active pixels; pixel i = R=i,G=55,B=AA unless rnd. Active pixels
    // of lines >= pop_from also strobe a DATA read in the same cycle.
    task automatic lines(input int nl, input int w, input int pop_from, input bit rnd);
        for (int l = 0; l < nl; l++) begin
            repeat (2) vid(0, 1, 0, 8'd0, 8'd0, 8'd0, rnd && $urandom_range(0, 2) == 0);
            repeat (2) vid(1, 1, 0, 8'd0, 8'd0, 8'd0, rnd && $urandom_range(0, 2) == 0);
            for (int p = 0; p < w; p++) begin
                if (rnd)
                    vid(1, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
                else
                    vid(1, 1, 1, 8'(l * w + p), 8'h55, 8'hAA, l >= pop_from);
            end
            repeat (2) vid(1, 1, 0, 8'd0, 8'd0, 8'd0, rnd && $urandom_range(0, 2) == 0);
        end
    endtask

    task automatic frame(input int nl, input int w, input int pop_from, input bit rnd);
        vs_pulse();
        lines(nl, w, pop_from, rnd);
        vs_pulse();
        idle(2);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1; write = 1; read = 0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1; read = 1; write = 0; address = a;
        @(negedge clk);
        chipselect = 0; read = 0;
        d = readdata;
    endtask

    task automatic expect_reg(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(nm, d, exp);
    endtask

    task automatic drain(input int n);
        logic [31:0] d;
        repeat (n) bus_read(2'd1, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
        VGA_R = 0; VGA_G = 0; VGA_B = 0; VGA_BLANK_n = 0; HSYNC = 1; VSYNC = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        cmp_en = 1;

        // reset state
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        expect_reg("reset_status", 2'd0, 32'h0000_0000);
        expect_reg("reset_decim", 2'd3, 32'h0000_0001);
        expect_reg("reset_pixcount", 2'd2, 32'h0000_0000);

        // full frame, DECIM=1, VSYNC already low when armed
        repeat (3) vid(1, 0, 0, 8'd0, 8'd0, 8'd0, 0);
        bus_write(2'd0, 32'h1);
        expect_reg("armed_status", 2'd0, 32'h0000_0001);
        frame(4, 8, 99, 0);
        chk("f1_irq", {31'd0, irq}, 32'h1);
        expect_reg("f1_status", 2'd0, 32'h0020_0004);
        expect_reg("f1_pixcount", 2'd2, 32'd32);
        expect_reg("f1_first_data", 2'd1, 32'h0055_AA00);
        expect_reg("f1_level31", 2'd0, 32'h001F_0004);
        bus_write(2'd2, 32'h4);
        drain(31);
        expect_reg("f1_drained", 2'd0, 32'h0000_0000);

        // DECIM=3: pixels 0,3,6 of each line
        bus_write(2'd3, 32'h3);
        expect_reg("decim3", 2'd3, 32'h3);
        bus_write(2'd0, 32'h1);
        frame(4, 8, 99, 0);
        expect_reg("d3_pixcount", 2'd2, 32'd12);
        expect_reg("d3_status", 2'd0, 32'h000C_0004);
        expect_reg("d3_pix0", 2'd1, 32'h0055_AA00);
        expect_reg("d3_pix3", 2'd1, 32'h0355_AA00);
        expect_reg("d3_pix6", 2'd1, 32'h0655_AA00);
        expect_reg("d3_pix8", 2'd1, 32'h0855_AA00);
        drain(8);
        bus_write(2'd2, 32'h4);

        // overflow: 48 pixels into a 32-deep FIFO
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h1);
        frame(6, 8, 99, 0);
        expect_reg("ovf_status", 2'd0, 32'h0020_0006);
        expect_reg("ovf_pixcount", 2'd2, 32'd32);
        bus_write(2'd2, 32'h2);
        expect_reg("ovf_cleared", 2'd0, 32'h0020_0004);
        expect_reg("ovf_first", 2'd1, 32'h0055_AA00);
        drain(31);
        expect_reg("udf_data", 2'd1, 32'h0000_0000);
        expect_reg("udf_status", 2'd0, 32'h0000_000C);
        bus_write(2'd2, 32'hE);
        expect_reg("flags_cleared", 2'd0, 32'h0000_0000);

        // push and pop together while full
        bus_write(2'd0, 32'h1);
        frame(6, 8, 4, 0);
        expect_reg("fullpp_status", 2'd0, 32'h0020_0004);
        expect_reg("fullpp_pixcount", 2'd2, 32'd48);
        bus_write(2'd0, 32'h2);
        expect_reg("abort_status", 2'd0, 32'h0000_0004);
        expect_reg("abort_pixcount", 2'd2, 32'h0);
        bus_write(2'd2, 32'h4);

        // continuous capture, abort mid frame 3
        bus_write(2'd0, 32'h5);
        vs_pulse();
        lines(2, 4, 99, 0);
        vs_pulse();
        idle(2);
        expect_reg("cont_f1", 2'd0, 32'h0008_0005);
        bus_write(2'd2, 32'h4);
        expect_reg("cont_f1_clr", 2'd0, 32'h0008_0001);
        lines(2, 4, 99, 0);
        vs_pulse();
        idle(2);
        expect_reg("cont_f2", 2'd0, 32'h0010_0005);
        lines(1, 4, 99, 0);
        bus_write(2'd0, 32'h2);
        expect_reg("cont_abort", 2'd0, 32'h0000_0004);

        // start and abort together stays idle
        bus_write(2'd2, 32'h4);
        bus_write(2'd0, 32'h3);
        expect_reg("sa_status", 2'd0, 32'h0000_0000);
        frame(2, 4, 99, 0);
        expect_reg("sa_after", 2'd0, 32'h0000_0000);
        expect_reg("sa_pixcount", 2'd2, 32'h0);

        // randomized frames with random DECIM and interleaved DATA reads
        for (int r = 0; r < 8; r++) begin
            bus_write(2'd3, 32'($urandom_range(0, 4)));
            bus_write(2'd0, 32'h1);
            frame($urandom_range(1, 4), $urandom_range(1, 10), 99, 1);
            drain(45);
            bus_write(2'd2, 32'hE);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
